// File: rtl/uart_cmd_wrapper.sv
// UART command front end: receives two-byte commands on RX and transmits
// single-byte responses on TX, both framed 8N1 at BAUD_DIV clocks per bit.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] RX_FULL   = CW'(BAUD_DIV);
    localparam logic [CW-1:0] RX_HALF   = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] TX_RELOAD = CW'(BAUD_DIV - 1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [3:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            byte_vld_q, byte_vld_d;

    asm_state_t      asm_q, asm_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_idx_q, tx_idx_d;
    logic [8:0]      tx_frame_q, tx_frame_d;
    logic            tx_q, tx_d;
    logic            resp_sent_q, resp_sent_d;

    // rx_prev_q tracks the synchronized line so a start needs a real falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh_q    <= rx_sh_d;
        tx_frame_q <= tx_frame_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        byte_vld_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RX_RECV;
                    rx_cnt_d   = RX_HALF;
                    rx_idx_d   = 4'd0;
                end
            end
            RX_RECV: begin
                if (rx_cnt_q == CW'(1)) begin
                    rx_cnt_d = RX_FULL;
                    if (rx_idx_q == 4'd9) begin
                        // stop sample decides whether the byte is delivered
                        byte_vld_d = rx_sync2_q;
                        rx_state_d = RX_IDLE;
                    end else begin
                        if (rx_idx_q != 4'd0) begin
                            rx_sh_d = {rx_sync2_q, rx_sh_q[7:1]};
                        end
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= WAIT_HIGH;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // a completing low byte overrides a simultaneous clear
    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (byte_vld_q) begin
            case (asm_q)
                WAIT_HIGH: begin
                    cmd_d[15:8] = rx_sh_q;
                    cmd_rdy_d   = 1'b0;
                    asm_d       = WAIT_LOW;
                end
                WAIT_LOW: begin
                    cmd_d[7:0] = rx_sh_q;
                    cmd_rdy_d  = 1'b1;
                    asm_d      = WAIT_HIGH;
                end
                default: asm_d = WAIT_HIGH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // tx_frame_q holds the bits still to go out after the one on TX, LSB next
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_frame_d  = tx_frame_q;
        tx_d        = tx_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_frame_d  = {1'b1, resp};
                    tx_d        = 1'b0;
                    tx_cnt_d    = TX_RELOAD;
                    tx_idx_d    = 4'd0;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == '0) begin
                    if (tx_idx_q == 4'd9) begin
                        tx_d        = 1'b1;
                        resp_sent_d = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end else begin
                        tx_d       = tx_frame_q[0];
                        tx_frame_d = {1'b1, tx_frame_q[8:1]};
                        tx_idx_d   = tx_idx_q + 4'd1;
                        tx_cnt_d   = TX_RELOAD;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: command assembly, response framing,
// bad stop bits, mid-frame reset and clear/set collision.
module tb_uart_cmd_wrapper;

    localparam int B = 16;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int errors = 0;
    int checks = 0;

    uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // start bit plus 8 data bits, each held B clocks; caller drives the stop bit
    task automatic send_head(input logic [7:0] d);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic sb);
        send_head(d);
        RX = sb;
        repeat (B) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
        rst_n = 1'b1;
        repeat (4 * B) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h0000) begin
            errors++; $display("FAIL no_spurious_start: got cmd=%h rdy=%b expected 0000/0", cmd, cmd_rdy);
        end
    endtask

    task automatic test_cmd_basic;
        send_frame(8'h60, 1'b1);
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h6000) begin
            errors++; $display("FAIL gap_after_high: got cmd=%h rdy=%b expected 6000/0", cmd, cmd_rdy);
        end
        repeat (B) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL gap_rdy: got %b expected 0", cmd_rdy); end
        send_head(8'h20);
        RX = 1'b1;
        repeat (11) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rdy_early: got %b expected 0", cmd_rdy); end
        @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rdy_latency: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 16'h6020) begin errors++; $display("FAIL cmd_6020: got %h expected 6020", cmd); end
        repeat (B - 12) @(negedge clk);
    endtask

    task automatic test_clr;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
        checks++; if (cmd !== 16'h6020) begin errors++; $display("FAIL clr_cmd_hold: got %h expected 6020", cmd); end
        send_frame(8'h29, 1'b1);
        send_frame(8'h00, 1'b1);
        checks++; if (cmd !== 16'h2900 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL cmd_2900: got cmd=%h rdy=%b expected 2900/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_bad_stop;
        send_frame(8'h77, 1'b0);
        repeat (2 * B) @(negedge clk);
        checks++; if (cmd !== 16'h2900 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL bad_stop_dropped: got cmd=%h rdy=%b expected 2900/1", cmd, cmd_rdy);
        end
        send_frame(8'h40, 1'b1);
        checks++; if (cmd !== 16'h4000 || cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL bad_stop_high: got cmd=%h rdy=%b expected 4000/0", cmd, cmd_rdy);
        end
        send_frame(8'h00, 1'b1);
        checks++; if (cmd !== 16'h4000 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL bad_stop_cmd: got cmd=%h rdy=%b expected 4000/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_resp;
        logic [9:0] pat;
        pat = 10'b1101001010;
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int c = 0; c < 10 * B; c++) begin
            checks++; if (TX !== pat[c / B]) begin
                errors++; $display("FAIL tx_bit c=%0d: got %b expected %b", c, TX, pat[c / B]);
            end
            checks++; if (resp_sent !== 1'b0) begin
                errors++; $display("FAIL resp_sent_early c=%0d: got %b expected 0", c, resp_sent);
            end
            if (c == 50) begin resp = 8'h5A; send_resp = 1'b1; end
            if (c == 51) send_resp = 1'b0;
            @(negedge clk);
        end
        checks++; if (resp_sent !== 1'b1 || TX !== 1'b1) begin
            errors++; $display("FAIL resp_done: got sent=%b tx=%b expected 1/1", resp_sent, TX);
        end
        repeat (2 * B) @(negedge clk);
        checks++; if (resp_sent !== 1'b1 || TX !== 1'b1) begin
            errors++; $display("FAIL resp_hold: got sent=%b tx=%b expected 1/1", resp_sent, TX);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        d = 8'h55;
        RX = 1'b0;
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL resp_sent_clear: got %b expected 0", resp_sent); end
        repeat (B - 1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = d[i];
            repeat (B) @(negedge clk);
        end
        RX = d[3];
        repeat (8) @(negedge clk);
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL tx_before_reset: got %b expected 0", TX); end
        rst_n = 1'b0;
        #1;
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", TX); end
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h0000) begin
            errors++; $display("FAIL midreset_cmd: got cmd=%h rdy=%b expected 0000/0", cmd, cmd_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        RX = 1'b1;
        repeat (3 * B) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0 || TX !== 1'b1 || resp_sent !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got rdy=%b tx=%b sent=%b expected 0/1/0", cmd_rdy, TX, resp_sent);
        end
        send_frame(8'h30, 1'b1);
        send_frame(8'h10, 1'b1);
        checks++; if (cmd !== 16'h3010 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL cmd_3010: got cmd=%h rdy=%b expected 3010/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_reset_partial;
        send_frame(8'h11, 1'b1);
        checks++; if (cmd !== 16'h1110 || cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL partial_high: got cmd=%h rdy=%b expected 1110/0", cmd, cmd_rdy);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (B) @(negedge clk);
        send_frame(8'h30, 1'b1);
        send_frame(8'h10, 1'b1);
        checks++; if (cmd !== 16'h3010 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL partial_lost: got cmd=%h rdy=%b expected 3010/1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_clr_coincide;
        send_frame(8'h44, 1'b1);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL coincide_high: got %b expected 0", cmd_rdy); end
        send_head(8'h55);
        RX = 1'b1;
        repeat (11) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== 16'h4455) begin errors++; $display("FAIL cmd_4455: got %h expected 4455", cmd); end
        repeat (B - 12) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        send_resp = 1'b0;
        test_reset();
        test_cmd_basic();
        test_clr();
        test_bad_stop();
        test_resp();
        test_reset_midframe();
        test_reset_partial();
        test_clr_coincide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter: BAUD_DIV, default 2604, clocks per UART bit (19200 baud at 50 MHz); legal range 16..4095.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: RX  input  1  serial command line from the remote; idles high.
REQ-005 Port: TX  output  1  serial response line to the remote; idles high.
REQ-006 Port: cmd  output  16  assembled command, {first byte, second byte}.
REQ-007 Port: cmd_rdy  output  1  high while cmd holds a complete, unconsumed command.
REQ-008 Port: clr_cmd_rdy  input  1  one-cycle pulse from the command processor: command consumed.
REQ-009 Port: resp  input  8  response byte (0xA5 positive ack, 0x5A move ack).
REQ-010 Port: send_resp  input  1  one-cycle pulse: transmit resp.
REQ-011 Port: resp_sent  output  1  high once the last response's stop bit has completed.

Function
REQ-012 RX path: RX passes through two flops, both preset to 1; only the second flop's output is used internally.
REQ-013 RX states: IDLE, RECV.
- IDLE -> RECV on a synchronized high-to-low transition.
- The bit counter loads BAUD_DIV/2 (integer) at the start edge.
REQ-014 RX sampling:
- In RECV, the line is sampled each time the baud counter expires, then the counter reloads BAUD_DIV.
- There are 10 samples: start, 8 data bits LSB first, stop.
- After the 10th sample the receiver returns to IDLE.
REQ-015 A received byte is valid only if the stop sample is 1; if the stop sample is 0 the byte is discarded and assembly state is unchanged.
- The start sample is not checked.
REQ-016 Assembly FSM states: WAIT_HIGH, WAIT_LOW.
- A valid byte in WAIT_HIGH: written to cmd[15:8], cmd_rdy cleared, next state WAIT_LOW.
- A valid byte in WAIT_LOW: written to cmd[7:0], cmd_rdy set the same cycle, next state WAIT_HIGH.
REQ-017 cmd_rdy clear conditions:
- clr_cmd_rdy clears cmd_rdy.
- If clr_cmd_rdy coincides with low-byte completion, set wins.
- cmd holds its value until overwritten byte-wise.
REQ-018 Latency: cmd_rdy rises exactly 1 clock after the stop-bit sample of the second byte.
REQ-019 TX states: IDLE, XMIT.
- send_resp in IDLE latches resp, clears resp_sent and enters XMIT.
- A frame is 10 bits (0, resp[0]..resp[7], 1), each held BAUD_DIV clocks.
- TX goes low on the clock after send_resp.
REQ-020 At the end of the stop bit, TX returns to IDLE and resp_sent is set; it stays high until the next accepted send_resp.
REQ-021 send_resp in XMIT is ignored; the in-flight byte completes unaltered.
REQ-022 RX and TX operate fully independently; full-duplex traffic is legal.
REQ-023 All counters are sized for BAUD_DIV and must not wrap within a bit period.

Reset
REQ-024 While rst_n is low, outputs and state take these values:
- TX = 1, cmd = 0x0000, cmd_rdy = 0, resp_sent = 0.
- RX sync flops = 1.
- Both FSMs in IDLE; assembly FSM in WAIT_HIGH.
REQ-025 Reset asserted mid-frame aborts RX and TX immediately.
- Any partially assembled command is lost; the next byte after reset is treated as a high byte.
REQ-026 After rst_n deasserts, no spurious start is detected while RX is high.

Verification
REQ-027 Bytes 0x60 then 0x20 on RX:
- cmd = 16'h6020 and cmd_rdy = 1, one clock after the second stop sample.
- cmd_rdy = 0 during the gap between the two bytes.
REQ-028 Pulse clr_cmd_rdy:
- cmd_rdy = 0 next clock; cmd is still 16'h6020.
- Send 0x29, 0x00: cmd = 16'h2900 and cmd_rdy = 1.
REQ-029 send_resp with resp = 0xA5:
- TX pattern 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clocks.
- resp_sent rises after 10*BAUD_DIV clocks.
- A second send_resp with 0x5A issued mid-frame is ignored.
REQ-030 First byte sent with stop bit forced 0, then 0x40, 0x00 sent normally: the bad byte is dropped and cmd = 16'h4000.
REQ-031 rst_n pulsed low during the 4th data bit of a high byte: TX = 1, cmd_rdy = 0; then 0x30, 0x10 yields cmd = 16'h3010.
REQ-032 clr_cmd_rdy asserted on the same clock as low-byte completion: cmd_rdy = 1 afterward.
